// File: rtl/sme_param.sv
// Parametrised string-matching engine: stores one string, then searches it for each streamed pattern.
// Optional build macro SME_NOCASE_EN folds ASCII letter case in literal comparisons.
module sme_param #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int IDX_W   = $clog2(STR_MAX + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       chardata,
   input  logic             isstring,
   input  logic             ispattern,
   output logic             busy,
   output logic             valid,
   output logic             match,
   output logic [IDX_W-1:0] match_index
);

   localparam int PL_W = $clog2(PAT_MAX + 1);
   localparam int SA_W = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
   localparam int PA_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
   localparam int CW   = ((PL_W > IDX_W) ? PL_W : IDX_W) + 1;

   localparam logic [IDX_W-1:0] STR_MAX_L = IDX_W'(STR_MAX);
   localparam logic [PL_W-1:0]  PAT_MAX_L = PL_W'(PAT_MAX);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_STR = 3'd1;
   localparam logic [2:0] S_LOAD_PAT = 3'd2;
   localparam logic [2:0] S_SEARCH   = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_SPACE  = 8'h20;

`ifdef SME_NOCASE_EN
   function automatic logic [7:0] fold(input logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
   endfunction
`else
   function automatic logic [7:0] fold(input logic [7:0] c);
      return c;
   endfunction
`endif

   logic [2:0]       state;
   logic [2:0]       state_nx;
   logic [7:0]       str_mem [STR_MAX];
   logic [7:0]       pat_mem [PAT_MAX];
   logic [IDX_W-1:0] str_len;
   logic [PL_W-1:0]  pat_len;
   logic [IDX_W-1:0] cand;
   logic             match_r;
   logic [IDX_W-1:0] index_r;

   logic str_first;
   logic str_app;
   logic pat_first;
   logic pat_app;

   // Anchor decode and count of consuming pattern chars
   logic            sa;
   logic            ea;
   logic [PL_W-1:0] k;

   assign sa = (pat_len != '0) && (pat_mem[0] == CH_CARET);
   assign ea = (pat_len != '0) && (pat_mem[PA_W'(pat_len - 1'b1)] == CH_DOLLAR);
   assign k  = pat_len - PL_W'(sa) - PL_W'(ea);

   logic [CW-1:0] cand_w;
   logic [CW-1:0] k_w;
   logic [CW-1:0] slen_w;
   logic [CW-1:0] epos;

   assign cand_w = CW'(cand);
   assign k_w    = CW'(k);
   assign slen_w = CW'(str_len);
   assign epos   = cand_w + k_w;

   logic [PAT_MAX-1:0] char_ok;

   for (genvar j = 0; j < PAT_MAX; j++) begin : g_cmp
      logic [7:0] pc;
      logic [7:0] sc;
      assign pc = pat_mem[PA_W'(PL_W'(j) + PL_W'(sa))];
      assign sc = str_mem[SA_W'(cand_w + CW'(j))];
      assign char_ok[j] = (PL_W'(j) >= k) || (pc == CH_DOT) || (fold(pc) == fold(sc));
   end

   logic no_cand;
   logic start_ok;
   logic end_ok;
   logic hit;
   logic last_cand;
   logic search_end;

   assign no_cand    = k_w > slen_w;
   assign start_ok   = !sa || (cand == '0) || (str_mem[SA_W'(cand - 1'b1)] == CH_SPACE);
   assign end_ok     = !ea || (epos == slen_w) || (str_mem[SA_W'(epos)] == CH_SPACE);
   assign hit        = !no_cand && start_ok && end_ok && (&char_ok);
   assign last_cand  = (epos == slen_w);
   assign search_end = no_cand || hit || last_cand;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      str_first = 1'b0;
      str_app   = 1'b0;
      pat_first = 1'b0;
      pat_app   = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (isstring) begin
               state_nx  = S_LOAD_STR;
               str_first = 1'b1;
            end else if (ispattern) begin
               state_nx  = S_LOAD_PAT;
               pat_first = 1'b1;
            end else begin
               state_nx  = S_IDLE;
            end
         end
         S_LOAD_STR: begin
            if (isstring) begin
               str_app = 1'b1;
            end else if (ispattern) begin
               state_nx  = S_LOAD_PAT;
               pat_first = 1'b1;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_LOAD_PAT: begin
            if (ispattern) pat_app = 1'b1;
            else           state_nx = S_SEARCH;
         end
         S_SEARCH: begin
            if (search_end) state_nx = S_DONE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: character buffers carry no reset; the length registers alone define what is valid.
   always_ff @(posedge clk) begin
      if (str_first)
         str_mem[0] <= chardata;
      else if (str_app && str_len != STR_MAX_L)
         str_mem[SA_W'(str_len)] <= chardata;
      if (pat_first)
         pat_mem[0] <= chardata;
      else if (pat_app && pat_len != PAT_MAX_L)
         pat_mem[PA_W'(pat_len)] <= chardata;
   end

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         str_len <= '0;
         pat_len <= '0;
         cand    <= '0;
         match_r <= 1'b0;
         index_r <= '0;
      end else begin
         state <= state_nx;

         if (str_first)
            str_len <= IDX_W'(1);
         else if (str_app && str_len != STR_MAX_L)
            str_len <= str_len + 1'b1;

         if (pat_first)
            pat_len <= PL_W'(1);
         else if (pat_app && pat_len != PAT_MAX_L)
            pat_len <= pat_len + 1'b1;

         // One candidate start position is evaluated per SEARCH cycle
         if (state == S_LOAD_PAT)
            cand <= '0;
         else if (state == S_SEARCH && !search_end)
            cand <= cand + 1'b1;

         if (state == S_SEARCH && search_end) begin
            match_r <= hit;
            index_r <= hit ? cand : '0;
         end
      end
   end

   assign valid       = (state == S_DONE);
   assign busy        = (state == S_LOAD_PAT) || (state == S_SEARCH) || (state == S_DONE);
   assign match       = valid && match_r;
   assign match_index = valid ? index_r : '0;

endmodule

// File: doc/sme_param.md
Name: sme_param

Overview:
- Parametrised string-matching engine, successor to the fixed 32-char / 8-char matcher in the univ-cell flow.
- Stores one string of up to STR_MAX chars, then searches it for each pattern streamed in.
- Patterns are up to PAT_MAX chars and support '^', '$' and '.'.
- Adds a busy indication, saturating overflow handling, a defined empty-string result and a guaranteed worst-case latency.

Parameters:
- STR_MAX, 32: max stored string length in chars.
- PAT_MAX, 8: max pattern length in chars, anchors included.
- IDX_W, $clog2(STR_MAX+1): width of match_index.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- chardata  in  8  ASCII character, sampled while isstring or ispattern is high.
- isstring  in  1  high for consecutive cycles while string chars stream in.
- ispattern  in  1  high for consecutive cycles while pattern chars stream in.
- busy  out  1  high from first pattern char until the valid cycle inclusive.
- valid  out  1  one-cycle result strobe.
- match  out  1  pattern found; meaningful only with valid.
- match_index  out  IDX_W  0-based start position; 0 when valid=0 or match=0.

Behaviour:
- Reset (reset_n=0, async): state IDLE; string length 0; pattern length 0; busy, valid, match, match_index all 0.
- States:
  - IDLE -> LOAD_STR on isstring; -> LOAD_PAT on ispattern.
  - LOAD_STR -> LOAD_PAT on ispattern; -> IDLE when both inputs are low.
  - LOAD_PAT -> SEARCH the cycle after ispattern falls.
  - SEARCH -> DONE on a hit or when candidates are exhausted.
  - DONE (valid=1) -> LOAD_STR / LOAD_PAT / IDLE according to the inputs in that cycle.
- String loading:
  - First isstring cycle of a burst clears the old string; each cycle appends one char.
  - Chars beyond STR_MAX are dropped; length saturates at STR_MAX.
- Pattern loading: same rules, saturating at PAT_MAX.
- Input priority:
  - isstring and ispattern both high: isstring wins.
  - Inputs while in SEARCH are ignored; the host must wait for valid.
- Pattern semantics:
  - '^' (0x5E) is special only as the first char: zero-width; satisfied at string position 0 or right after 0x20.
  - '$' (0x24) is special only as the last char: zero-width; satisfied at string end or right before 0x20.
  - '.' (0x2E) matches any single char.
  - Any other char, or '^'/'$' in any other position, compares literally.
- Search:
  - Candidate start positions are i = 0..len-k, ascending, where k = count of consuming chars; one candidate per cycle.
  - The first hit wins: match=1, match_index=i, where i is the position of the first consuming char.
  - If k=0 (pattern "^", "$" or "^$"): candidates are 0..len, and the result is the first position satisfying the anchors.
  - If k > len, or no hit: match=0, match_index=0.
- Latency: valid asserts at most STR_MAX+2 cycles after ispattern falls, and is high for exactly one cycle.
- Empty string (after reset or before any isstring):
  - Patterns with k≥1 give no match.
  - "^", "$" and "^$" match at index 0.
- Reset mid-operation: aborts any load or search; no valid pulse; the string buffer is empty afterwards.
- The stored string persists across any number of patterns until the next isstring burst.

Optional Feature:
- Macro: SME_NOCASE_EN.
- When defined: literal comparisons fold ASCII A-Z/a-z to the same case. '.', '^' and '$' are unaffected.
- When undefined: exact 8-bit comparison.

Test Plan:
- String "hello world", pattern "wor" -> single valid pulse; match=1, index=6; busy falls with valid.
- Same string, patterns "^wo", "^or", "w.r" -> (1,6), (0,0), (1,6) respectively, without reloading the string.
- Same string, patterns "lo$", "d$", "$" -> (1,3), (1,10), (1,5).
- STR_MAX=32: string of 39 'a' then 'b' (40 chars) -> 'b' dropped. Pattern "b" -> (0,0) with valid ≤34 cycles after ispattern falls. Pattern "a$" -> (1,31).
- Pattern "abcdefghij" with PAT_MAX=8 -> stored as "abcdefgh". String "xabcdefgh" -> (1,1).
- reset_n pulsed low during SEARCH -> no valid, busy=0. Next pattern "a" -> (0,0); pattern "^$" -> (1,0).
- SME_NOCASE_EN defined: "hello world" / "WOR" -> (1,6). Undefined: (0,0).
